// File: rtl/lm_sm_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lm_sm_sequencer_pkg : shared types and defaults for the LM/SM sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
package lm_sm_sequencer_pkg;

    localparam int LM_ADDR_W_DEF = 5;
    localparam int LM_DATA_W_DEF = 16;
    localparam int REG_IDX_W     = 3;
    localparam int REG_CNT       = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lm_sm_sequencer_priority_enc8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// priority_enc8 : index of the lowest set bit of an 8-bit mask
// Revision: 1.0
// ---------------------------------------------------------------------------
module priority_enc8
    import lm_sm_sequencer_pkg::*;
(
    input  logic [REG_CNT-1:0]   mask_i,
    output logic [REG_IDX_W-1:0] idx_o,
    output logic                 valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = |mask_i;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = REG_CNT - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = REG_IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lm_sm_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lm_sm_sequencer : load/store-multiple sequencer, one register per cycle
// Revision: 1.0
// ---------------------------------------------------------------------------
module lm_sm_sequencer
    import lm_sm_sequencer_pkg::*;
#(
    parameter int ADDR_W = LM_ADDR_W_DEF,
    parameter int DATA_W = LM_DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 proc_rst,
    input  logic                 start,
    input  logic                 op_store,
    input  logic [REG_CNT-1:0]   reg_list,
    input  logic [ADDR_W-1:0]    base_addr,
    output logic [REG_IDX_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0]    rf_rdata,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_in,
    input  logic [DATA_W-1:0]    mem_out,
    output logic                 mem_write,
    output logic                 mem_read,
    output logic                 busy,
    output logic                 done
);

    state_t                 state_q,     state_d;
    logic [REG_CNT-1:0]     pending_q,   pending_d;
    logic [ADDR_W-1:0]      ptr_q,       ptr_d;
    logic                   op_q,        op_d;
    logic [ADDR_W-1:0]      mem_addr_q,  mem_addr_d;
    logic [REG_IDX_W-1:0]   rf_raddr_q,  rf_raddr_d;
    logic                   mem_write_q, mem_write_d;
    logic                   mem_read_q,  mem_read_d;
    logic                   rf_we_q,     rf_we_d;
    logic [REG_IDX_W-1:0]   rf_waddr_q,  rf_waddr_d;
    logic [DATA_W-1:0]      rf_wdata_q,  rf_wdata_d;

    logic [REG_CNT-1:0]     w_enc_in;
    logic [REG_IDX_W-1:0]   w_idx;
    logic                   w_valid;
    logic [REG_CNT-1:0]     w_clr_mask;

    // The first access is issued straight from the start inputs so that the
    // strobe is already low in the cycle after start was sampled.
    assign w_enc_in   = (state_q == ST_IDLE) ? reg_list : pending_q;
    assign w_clr_mask = ~(REG_CNT'(1) << w_idx);

    priority_enc8 u_prio (
        .mask_i  (w_enc_in),
        .idx_o   (w_idx),
        .valid_o (w_valid)
    );

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        ptr_d       = ptr_q;
        op_d        = op_q;
        mem_addr_d  = mem_addr_q;
        rf_raddr_d  = rf_raddr_q;
        mem_write_d = 1'b1;
        mem_read_d  = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d      = op_store;
                    pending_d = reg_list;
                    ptr_d     = base_addr;
                    if (w_valid) begin
                        state_d     = ST_ACCESS;
                        pending_d   = reg_list & w_clr_mask;
                        ptr_d       = base_addr + ADDR_W'(1);
                        mem_addr_d  = base_addr;
                        rf_raddr_d  = w_idx;
                        mem_write_d = ~op_store;
                        mem_read_d  = op_store;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_ACCESS: begin
                if (w_valid) begin
                    pending_d   = pending_q & w_clr_mask;
                    ptr_d       = ptr_q + ADDR_W'(1);
                    mem_addr_d  = ptr_q;
                    rf_raddr_d  = w_idx;
                    mem_write_d = ~op_q;
                    mem_read_d  = op_q;
                end else begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Load data is captured at the edge closing each read-strobe cycle and
    // written back to the register file during the following cycle.
    always_comb begin
        rf_we_d    = ~mem_read_q;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (!mem_read_q) begin
            rf_waddr_d = rf_raddr_q;
            rf_wdata_d = mem_out;
        end
    end

    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            ptr_q       <= '0;
            op_q        <= 1'b0;
            mem_addr_q  <= '0;
            rf_raddr_q  <= '0;
            mem_write_q <= 1'b1;
            mem_read_q  <= 1'b1;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            ptr_q       <= ptr_d;
            op_q        <= op_d;
            mem_addr_q  <= mem_addr_d;
            rf_raddr_q  <= rf_raddr_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

    assign rf_raddr  = rf_raddr_q;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_in    = rf_rdata;
    assign mem_write = mem_write_q;
    assign mem_read  = mem_read_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_lm_sm_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lm_sm_sequencer : self-checking bench with memory/register-file models
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_lm_sm_sequencer;

    logic        clk;
    logic        proc_rst;
    logic        start;
    logic        op_store;
    logic [7:0]  reg_list;
    logic [4:0]  base_addr;
    logic [2:0]  rf_raddr;
    logic [15:0] rf_rdata;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [4:0]  mem_addr;
    logic [15:0] mem_in;
    logic [15:0] mem_out;
    logic        mem_write;
    logic        mem_read;
    logic        busy;
    logic        done;

    logic [15:0] mem_m [32];
    logic [15:0] rf_m  [8];
    logic        pl_mem;
    logic        pl_rf;
    logic [4:0]  pl_a;
    logic [15:0] pl_d;

    int n_checks;
    int n_fail;

    lm_sm_sequencer #(.ADDR_W(5), .DATA_W(16)) dut (
        .clk       (clk),
        .proc_rst  (proc_rst),
        .start     (start),
        .op_store  (op_store),
        .reg_list  (reg_list),
        .base_addr (base_addr),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .mem_addr  (mem_addr),
        .mem_in    (mem_in),
        .mem_out   (mem_out),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_rdata = rf_m[rf_raddr];
    assign mem_out  = mem_m[mem_addr];

    // Environment: memory and register file respond to the DUT's strobes.
    always @(posedge clk) begin
        if (!mem_write) mem_m[mem_addr] <= mem_in;
        if (rf_we)      rf_m[rf_waddr]  <= rf_wdata;
        if (pl_mem)     mem_m[pl_a]     <= pl_d;
        if (pl_rf)      rf_m[pl_a[2:0]] <= pl_d;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic pl_write(input bit is_rf, input int a, input logic [15:0] d);
        pl_rf  = is_rf;
        pl_mem = !is_rf;
        pl_a   = 5'(a);
        pl_d   = d;
        @(posedge clk); #1;
        pl_rf  = 1'b0;
        pl_mem = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) pl_write(1'b0, i, 16'($urandom));
        for (int i = 0; i < 8; i++)  pl_write(1'b1, i, 16'($urandom));
    endtask

    task automatic idle(input int k);
        for (int c = 0; c < k; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_mem_write", mem_write, 1);
            chk("idle_mem_read", mem_read, 1);
            chk("idle_rf_we", rf_we, 0);
        end
    endtask

    // Starts a transfer in the next cycle (cycle 0) and checks cycles 1..N+1
    // against a trace derived from the selected-register list.
    task automatic run_xfer(input bit op, input logic [7:0] list, input logic [4:0] base,
                            input bit hold, output int n_strobe, output int done_cyc);
        int          idx[$];
        logic [15:0] snap_rf  [8];
        logic [15:0] snap_mem [32];
        int          n;
        logic [4:0]  a;
        @(posedge clk); #1;
        start     = 1'b1;
        op_store  = op;
        reg_list  = list;
        base_addr = base;
        for (int i = 0; i < 8; i++)  snap_rf[i]  = rf_m[i];
        for (int i = 0; i < 32; i++) snap_mem[i] = mem_m[i];
        idx.delete();
        for (int i = 0; i < 8; i++) if (list[i]) idx.push_back(i);
        n        = idx.size();
        n_strobe = 0;
        done_cyc = -1;
        for (int c = 1; c <= n + 1; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                start     = hold;
                op_store  = 1'($urandom);
                reg_list  = 8'($urandom);
                base_addr = 5'($urandom);
            end
            @(negedge clk);
            chk("busy", busy, 1);
            chk("done", done, (c == n + 1) ? 1 : 0);
            if (!mem_write || !mem_read) n_strobe++;
            if (done && done_cyc < 0) done_cyc = c;
            if (c <= n) begin
                a = 5'(int'(base) + c - 1);
                chk("mem_write", mem_write, op ? 0 : 1);
                chk("mem_read", mem_read, op ? 1 : 0);
                chk("mem_addr", mem_addr, a);
                chk("rf_raddr", rf_raddr, idx[c-1]);
                if (op) chk("mem_in", mem_in, snap_rf[idx[c-1]]);
            end else begin
                chk("end_mem_write", mem_write, 1);
                chk("end_mem_read", mem_read, 1);
            end
            if (!op && c >= 2) begin
                a = 5'(int'(base) + c - 2);
                chk("rf_we", rf_we, 1);
                chk("rf_waddr", rf_waddr, idx[c-2]);
                chk("rf_wdata", rf_wdata, snap_mem[a]);
            end else begin
                chk("rf_we_low", rf_we, 0);
            end
        end
    endtask

    typedef struct {
        bit         op;
        logic [7:0] list;
        logic [4:0] base;
        int         exp_n;
        int         exp_done;
    } vec_t;

    initial begin
        vec_t vt[7];
        int   ns, dc;
        bit   op_r, hold_r;
        logic [7:0] list_r;

        vt[0] = '{1'b1, 8'b1000_0101, 5'd3,  3, 4};
        vt[1] = '{1'b0, 8'h03,        5'd30, 2, 3};
        vt[2] = '{1'b0, 8'h07,        5'd31, 3, 4};
        vt[3] = '{1'b1, 8'h00,        5'd7,  0, 1};
        vt[4] = '{1'b0, 8'h00,        5'd0,  0, 1};
        vt[5] = '{1'b1, 8'hFF,        5'd28, 8, 9};
        vt[6] = '{1'b0, 8'h80,        5'd31, 1, 2};

        n_checks  = 0;
        n_fail    = 0;
        start     = 1'b0;
        op_store  = 1'b0;
        reg_list  = 8'h00;
        base_addr = 5'd0;
        pl_mem    = 1'b0;
        pl_rf     = 1'b0;
        pl_a      = 5'd0;
        pl_d      = 16'h0;
        proc_rst  = 1'b1;
        #1 proc_rst = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_write", mem_write, 1);
        chk("rst_mem_read", mem_read, 1);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rf_raddr", rf_raddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);

        @(posedge clk); #1;
        fill_random();
        proc_rst = 1'b1;
        idle(2);

        for (int i = 0; i < 7; i++) begin
            if (i == 0) begin
                pl_write(1'b1, 0, 16'hA1A1);
                pl_write(1'b1, 2, 16'hB2B2);
                pl_write(1'b1, 7, 16'hC3C3);
            end else if (i == 1) begin
                pl_write(1'b0, 30, 16'h1111);
                pl_write(1'b0, 31, 16'h2222);
            end else if (i == 2) begin
                pl_write(1'b0, 31, 16'h3131);
                pl_write(1'b0, 0,  16'h0A0A);
                pl_write(1'b0, 1,  16'h0B0B);
            end
            run_xfer(vt[i].op, vt[i].list, vt[i].base, 1'b0, ns, dc);
            chk("vec_strobes", 32'(ns), 32'(vt[i].exp_n));
            chk("vec_done_cycle", 32'(dc), 32'(vt[i].exp_done));
            idle(1);
            if (i == 0) begin
                chk("sm_mem3", mem_m[3], 16'hA1A1);
                chk("sm_mem4", mem_m[4], 16'hB2B2);
                chk("sm_mem5", mem_m[5], 16'hC3C3);
            end else if (i == 1) begin
                chk("lm_r0", rf_m[0], 16'h1111);
                chk("lm_r1", rf_m[1], 16'h2222);
            end else if (i == 2) begin
                chk("wrap_r0", rf_m[0], 16'h3131);
                chk("wrap_r1", rf_m[1], 16'h0A0A);
                chk("wrap_r2", rf_m[2], 16'h0B0B);
            end
        end

        // Reset in cycle 2 of an 8-register store aborts the transfer.
        @(posedge clk); #1;
        start     = 1'b1;
        op_store  = 1'b1;
        reg_list  = 8'hFF;
        base_addr = 5'd10;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("abort_c1_write", mem_write, 0);
        @(posedge clk); #1;
        proc_rst = 1'b0;
        #1;
        chk("abort_mem_write", mem_write, 1);
        chk("abort_mem_read", mem_read, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_rf_raddr", rf_raddr, 0);
        chk("abort_rf_waddr", rf_waddr, 0);
        chk("abort_rf_wdata", rf_wdata, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_hold_write", mem_write, 1);
            chk("abort_hold_done", done, 0);
        end
        @(posedge clk); #1;
        proc_rst = 1'b1;
        idle(4);
        run_xfer(1'b0, 8'h81, 5'd20, 1'b0, ns, dc);
        chk("post_rst_strobes", 32'(ns), 2);
        chk("post_rst_done", 32'(dc), 3);
        idle(1);

        // Start held high: the second transfer follows the first one's done.
        run_xfer(1'b0, 8'h0C, 5'd5, 1'b1, ns, dc);
        chk("hold_a_done", 32'(dc), 3);
        run_xfer(1'b1, 8'h30, 5'd9, 1'b0, ns, dc);
        chk("hold_b_done", 32'(dc), 3);
        idle(1);

        for (int it = 0; it < 24; it++) begin
            if (it % 8 == 0) fill_random();
            op_r   = 1'($urandom);
            hold_r = 1'($urandom);
            list_r = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            run_xfer(op_r, list_r, 5'($urandom), hold_r, ns, dc);
            chk("rnd_strobes", 32'(ns), 32'($countones(list_r)));
            chk("rnd_done", 32'(dc), 32'($countones(list_r) + 1));
            if (!hold_r || it % 8 == 7) idle(1);
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
